// File: rtl/ct_divider_taint_track_bitwise.sv
// Constant-time restoring divider with per-bit taint shadow.
// Every division takes the same number of cycles regardless of operand values;
// both the subtract and the restore path are evaluated each iteration and the
// borrow only selects between them. Taint is propagated conservatively: any
// taint reaching the compare makes the quotient bit and the whole remainder tainted.
module ct_divider_taint_track_bitwise #(
    parameter int NUM_BITS = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] dividend,
    input  logic [NUM_BITS-1:0] divisor,
    input  logic                start_t,
    input  logic [NUM_BITS-1:0] dividend_t,
    input  logic [NUM_BITS-1:0] divisor_t,
    output logic [NUM_BITS-1:0] quotient,
    output logic [NUM_BITS-1:0] remainder,
    output logic [NUM_BITS-1:0] quotient_t,
    output logic [NUM_BITS-1:0] remainder_t,
    output logic                busy,
    output logic                done,
    output logic                done_t
);

    localparam int N  = NUM_BITS;
    localparam int CW = $clog2(NUM_BITS + 1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(NUM_BITS);
    localparam logic [N-1:0]  ALL_ONES  = {N{1'b1}};
    localparam logic [N-1:0]  ALL_ZEROS = {N{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d, q_q, q_d;
    logic [N-1:0]   dvd_t_q, dvd_t_d, dvs_t_q, dvs_t_d, rem_t_q, rem_t_d, q_t_q, q_t_d;
    logic           tag_q, tag_d;
    logic [N-1:0]   quotient_q, quotient_d, remainder_q, remainder_d;
    logic [N-1:0]   quotient_t_q, quotient_t_d, remainder_t_q, remainder_t_d;
    logic           busy_q, busy_d, done_q, done_d, done_t_q, done_t_d;

    logic [N:0]     sh_s, trial_s, sh_t_s;
    logic           borrow_s, qbit_s, cmp_t_s, smear_acc_s;
    logic [N-1:0]   smear_s, rem_nx_s, rem_t_nx_s;

    // One restoring-division step plus its taint shadow, evaluated every cycle.
    always_comb begin
        sh_s     = {rem_q, dvd_q[N-1]};
        trial_s  = sh_s - {1'b0, dvs_q};
        borrow_s = trial_s[N];
        sh_t_s   = {rem_t_q, dvd_t_q[N-1]};
        cmp_t_s  = (|sh_t_s) | (|dvs_t_q);
        smear_acc_s = 1'b0;
        smear_s     = ALL_ZEROS;
        // A tainted low bit can ripple a borrow into every higher bit.
        for (int i = 0; i < N; i++) begin
            smear_acc_s = smear_acc_s | sh_t_s[i] | dvs_t_q[i];
            smear_s[i]  = smear_acc_s;
        end
        if (borrow_s) begin
            rem_nx_s = sh_s[N-1:0];
            qbit_s   = 1'b0;
        end else begin
            rem_nx_s = trial_s[N-1:0];
            qbit_s   = 1'b1;
        end
        if (cmp_t_s) begin
            rem_t_nx_s = ALL_ONES;
        end else if (!borrow_s) begin
            rem_t_nx_s = smear_s;
        end else begin
            rem_t_nx_s = sh_t_s[N-1:0];
        end
    end

    // Next-state and datapath control for IDLE / RUN / DONE.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dvd_d         = dvd_q;
        dvs_d         = dvs_q;
        rem_d         = rem_q;
        q_d           = q_q;
        dvd_t_d       = dvd_t_q;
        dvs_t_d       = dvs_t_q;
        rem_t_d       = rem_t_q;
        q_t_d         = q_t_q;
        tag_d         = tag_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        quotient_t_d  = quotient_t_q;
        remainder_t_d = remainder_t_q;
        done_t_d      = done_t_q;
        done_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = CNT_ZERO;
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    rem_d   = ALL_ZEROS;
                    q_d     = ALL_ZEROS;
                    dvd_t_d = dividend_t;
                    dvs_t_d = divisor_t;
                    rem_t_d = ALL_ZEROS;
                    q_t_d   = ALL_ZEROS;
                    tag_d   = start_t;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d   = cnt_q + CNT_ONE;
                    rem_d   = rem_nx_s;
                    q_d     = {q_q[N-2:0], qbit_s};
                    dvd_d   = {dvd_q[N-2:0], 1'b0};
                    rem_t_d = rem_t_nx_s;
                    q_t_d   = {q_t_q[N-2:0], cmp_t_s};
                    dvd_t_d = {dvd_t_q[N-2:0], 1'b0};
                end else begin
                    // All iterations finished: publish results together with done.
                    state_d       = S_DONE;
                    quotient_d    = q_q;
                    remainder_d   = rem_q;
                    quotient_t_d  = q_t_q;
                    remainder_t_d = rem_t_q;
                    done_t_d      = tag_q;
                    done_d        = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_RUN) && (cnt_d != CNT_LAST);
    end

    // State and datapath registers; reset clears everything including taints.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= CNT_ZERO;
            dvd_q         <= ALL_ZEROS;
            dvs_q         <= ALL_ZEROS;
            rem_q         <= ALL_ZEROS;
            q_q           <= ALL_ZEROS;
            dvd_t_q       <= ALL_ZEROS;
            dvs_t_q       <= ALL_ZEROS;
            rem_t_q       <= ALL_ZEROS;
            q_t_q         <= ALL_ZEROS;
            tag_q         <= 1'b0;
            quotient_q    <= ALL_ZEROS;
            remainder_q   <= ALL_ZEROS;
            quotient_t_q  <= ALL_ZEROS;
            remainder_t_q <= ALL_ZEROS;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            done_t_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dvd_q         <= dvd_d;
            dvs_q         <= dvs_d;
            rem_q         <= rem_d;
            q_q           <= q_d;
            dvd_t_q       <= dvd_t_d;
            dvs_t_q       <= dvs_t_d;
            rem_t_q       <= rem_t_d;
            q_t_q         <= q_t_d;
            tag_q         <= tag_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            quotient_t_q  <= quotient_t_d;
            remainder_t_q <= remainder_t_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            done_t_q      <= done_t_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign quotient_t  = quotient_t_q;
    assign remainder_t = remainder_t_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign done_t      = done_t_q;

endmodule

// File: tb/tb_ct_divider_taint_track_bitwise.sv
// Randomised bench for the constant-time taint-tracking divider, checked every
// cycle against an arithmetic reference model, plus literal spot checks.
module tb_ct_divider_taint_track_bitwise;

    localparam int N = 7;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] dividend = '0, divisor = '0;
    logic         start_t = 1'b0;
    logic [N-1:0] dividend_t = '0, divisor_t = '0;
    logic [N-1:0] quotient, remainder, quotient_t, remainder_t;
    logic         busy, done, done_t;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // reference model state
    bit           m_active = 1'b0;
    int           m_phase  = 0;
    logic [N-1:0] m_q = '0, m_r = '0, m_qt = '0, m_rt = '0;
    logic         m_dt = 1'b0;
    logic [N-1:0] p_q, p_r, p_qt, p_rt;
    logic         p_dt;

    ct_divider_taint_track_bitwise #(.NUM_BITS(N)) dut (
        .clk(clk), .rst(rst), .start(start),
        .dividend(dividend), .divisor(divisor), .start_t(start_t),
        .dividend_t(dividend_t), .divisor_t(divisor_t),
        .quotient(quotient), .remainder(remainder),
        .quotient_t(quotient_t), .remainder_t(remainder_t),
        .busy(busy), .done(done), .done_t(done_t)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Results straight from the arithmetic definition and the taint rules.
    function automatic void mdl(input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic [N-1:0] at, input logic [N-1:0] bt,
                                output logic [N-1:0] q, output logic [N-1:0] r,
                                output logic [N-1:0] qt, output logic [N-1:0] rt);
        bit seen;
        if (b == 0) begin
            q = '1;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
        qt = '0;
        rt = '0;
        if (bt != 0) begin
            qt = '1;
            rt = '1;
        end else if (at != 0) begin
            // from the first tainted dividend bit onward every step is tainted
            seen = 1'b0;
            for (int i = N - 1; i >= 0; i--) begin
                if (at[i]) seen = 1'b1;
                qt[i] = seen;
            end
            rt = '1;
        end
    endfunction

    // Transaction-level timeline: accept, N busy cycles, one finishing cycle, done.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_phase  = 0;
            m_q = '0; m_r = '0; m_qt = '0; m_rt = '0; m_dt = 1'b0;
        end else if (m_active) begin
            m_phase++;
            if (m_phase == N + 1) begin
                m_q = p_q; m_r = p_r; m_qt = p_qt; m_rt = p_rt; m_dt = p_dt;
            end
            if (m_phase == N + 2) m_active = 1'b0;
        end else if (start) begin
            m_active = 1'b1;
            m_phase  = 0;
            mdl(dividend, divisor, dividend_t, divisor_t, p_q, p_r, p_qt, p_rt);
            p_dt = start_t;
        end
    end

    // Compare every output on every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", N'(busy), N'(m_active && m_phase <= N - 1));
            chk("done", N'(done), N'(m_active && m_phase == N + 1));
            chk("done_t", N'(done_t), N'(m_dt));
            chk("quotient", quotient, m_q);
            chk("remainder", remainder, m_r);
            chk("quotient_t", quotient_t, m_qt);
            chk("remainder_t", remainder_t, m_rt);
        end
    end

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
        end
    endtask

    task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] at, input logic [N-1:0] bt,
                          input logic st, input int hold);
        @(negedge clk);
        #1;
        start = 1'b1; dividend = a; divisor = b;
        dividend_t = at; divisor_t = bt; start_t = st;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            // operands change after acceptance; they must not matter
            dividend = N'($urandom); divisor = N'($urandom);
            dividend_t = N'($urandom); divisor_t = N'($urandom);
            start_t = 1'($urandom);
        end
        start = 1'b0;
    endtask

    task automatic run(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] at, input logic [N-1:0] bt, input logic st,
                       input bit lit, input logic [N-1:0] lq, input logic [N-1:0] lr,
                       input logic [N-1:0] lqt, input logic [N-1:0] lrt);
        launch(a, b, at, bt, st, 1 + int'($urandom_range(0, 4)));
        wait_done(name);
        if (lit) begin
            chk({name, "_q"}, quotient, lq);
            chk({name, "_r"}, remainder, lr);
            chk({name, "_qt"}, quotient_t, lqt);
            chk({name, "_rt"}, remainder_t, lrt);
            chk({name, "_dt"}, N'(done_t), N'(st));
        end
        @(posedge clk);
    endtask

    initial begin
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_q", quotient, 7'd0);
        chk("reset_busy", N'(busy), 7'd0);

        run("div100_7", 7'd100, 7'd7, 7'd0, 7'd0, 1'b0, 1'b1, 7'd14, 7'd2, 7'd0, 7'd0);
        run("div127_1", 7'd127, 7'd1, 7'd0, 7'd0, 1'b0, 1'b1, 7'd127, 7'd0, 7'd0, 7'd0);
        run("div0_0", 7'd0, 7'd0, 7'd0, 7'd0, 1'b0, 1'b1, 7'd127, 7'd0, 7'd0, 7'd0);
        run("div42_0", 7'd42, 7'd0, 7'd0, 7'd0, 1'b0, 1'b1, 7'd127, 7'd42, 7'd0, 7'd0);
        run("dvs_taint", 7'd100, 7'd7, 7'd0, 7'b0000001, 1'b0, 1'b1, 7'd14, 7'd2, 7'd127, 7'd127);
        run("dvd_taint", 7'd100, 7'd7, 7'b1000000, 7'd0, 1'b1, 1'b1, 7'd14, 7'd2, 7'd127, 7'd127);
        run("dvd_taint_mid", 7'd100, 7'd7, 7'b0000100, 7'd0, 1'b0, 1'b1, 7'd14, 7'd2, 7'd7, 7'd127);

        // reset three cycles into a run aborts it without a done pulse
        launch(7'd100, 7'd7, 7'd0, 7'd0, 1'b1, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        chk("abort_q", quotient, 7'd0);
        chk("abort_r", remainder, 7'd0);
        chk("abort_busy", N'(busy), 7'd0);
        chk("abort_done", N'(done), 7'd0);
        run("div92_5", 7'd92, 7'd5, 7'd0, 7'd0, 1'b0, 1'b1, 7'd18, 7'd2, 7'd0, 7'd0);

        for (int k = 0; k < 40; k++) begin
            run("rand", N'($urandom), ($urandom_range(0, 5) == 0) ? 7'd0 : N'($urandom),
                ($urandom_range(0, 2) == 0) ? N'($urandom) : 7'd0,
                ($urandom_range(0, 3) == 0) ? N'($urandom) : 7'd0,
                1'($urandom), 1'b0, 7'd0, 7'd0, 7'd0, 7'd0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
